// File: rtl/cpu_pkg.sv
// Shared load-path definitions: load type codes, load FSM encoding and the
// alignment rule used at accept time.
package cpu_pkg;

  localparam logic [2:0] LD_LW  = 3'b000;
  localparam logic [2:0] LD_LB  = 3'b001;
  localparam logic [2:0] LD_LBU = 3'b010;
  localparam logic [2:0] LD_LH  = 3'b011;
  localparam logic [2:0] LD_LHU = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RESP = 2'b10,
    ST_ERR  = 2'b11
  } ld_state_t;

  // Byte loads never fault; halfwords need an even address; every other
  // type code is treated as a word load.
  function automatic logic misaligned(input logic [2:0] ld_type, input logic [1:0] addr_lo);
    logic bad;
    case (ld_type)
      LD_LB, LD_LBU: bad = 1'b0;
      LD_LH, LD_LHU: bad = addr_lo[0];
      default:       bad = (addr_lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_load_unit_if.sv
// Data-memory read port: request/address towards memory, ack/data back.
interface dmem_load_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/dmem_load_extend.sv
// Little-endian lane select and sign/zero extension of a loaded word.
// Purely combinational so the bypass network can reuse it.
module dmem_load_extend
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  ld_type,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    case (ld_type)
      LD_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  result = {24'h0, byte_sel};
      LD_LH:   result = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_load_unit.sv
// MEM-stage load unit: issues a req/ack read to variable-latency data memory,
// extends the returned data for write-back, and reports AdEL and bus timeouts.
module dmem_load_unit
  import cpu_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] RESET_BADV  = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ld_valid,
  input  logic [2:0]              ld_type,
  input  logic [31:0]             ld_addr,
  input  logic [4:0]              ld_rd,
  input  logic                    flush,
  output logic                    stall,
  dmem_load_unit_if.master        mem,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [31:0]             wb_data,
  output logic                    adel,
  output logic                    bus_err,
  output logic [31:0]             badvaddr
);

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);

  ld_state_t   state_reg;
  logic [2:0]  type_reg;
  logic [31:0] addr_reg;
  logic [4:0]  rd_reg;
  logic        kill_reg;
  logic [31:0] tmo_cnt_reg;
  logic        mem_req_reg;
  logic [31:0] mem_addr_reg;
  logic        wb_valid_reg;
  logic [4:0]  wb_rd_reg;
  logic [31:0] wb_data_reg;
  logic        adel_reg;
  logic        bus_err_reg;
  logic [31:0] badvaddr_reg;
  logic [31:0] ext_data;
  logic        accept;

  dmem_load_extend u_extend (
    .rdata   (mem.mem_rdata),
    .addr    (addr_reg[1:0]),
    .ld_type (type_reg),
    .result  (ext_data)
  );

  assign accept = ld_valid && (state_reg != ST_REQ);
  // A killed load still owns the bus but no longer holds the pipeline.
  assign stall  = accept || (state_reg == ST_REQ && !kill_reg && !flush);

  assign mem.mem_req  = mem_req_reg;
  assign mem.mem_addr = mem_addr_reg;
  assign wb_valid     = wb_valid_reg;
  assign wb_rd        = wb_rd_reg;
  assign wb_data      = wb_data_reg;
  assign adel         = adel_reg;
  assign bus_err      = bus_err_reg;
  assign badvaddr     = badvaddr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      type_reg     <= LD_LW;
      addr_reg     <= 32'h0;
      rd_reg       <= 5'd0;
      kill_reg     <= 1'b0;
      tmo_cnt_reg  <= 32'h0;
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= 32'h0;
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= 5'd0;
      wb_data_reg  <= 32'h0;
      adel_reg     <= 1'b0;
      bus_err_reg  <= 1'b0;
      badvaddr_reg <= RESET_BADV;
    end else begin
      wb_valid_reg <= 1'b0;
      adel_reg     <= 1'b0;
      bus_err_reg  <= 1'b0;
      case (state_reg)
        ST_REQ: begin
          if (flush) kill_reg <= 1'b1;
          // Ack has priority over a timeout landing in the same cycle.
          if (mem.mem_ack) begin
            mem_req_reg <= 1'b0;
            tmo_cnt_reg <= 32'h0;
            kill_reg    <= 1'b0;
            if (kill_reg || flush) begin
              state_reg <= ST_IDLE;
            end else begin
              state_reg    <= ST_RESP;
              wb_valid_reg <= 1'b1;
              wb_rd_reg    <= rd_reg;
              wb_data_reg  <= ext_data;
            end
          end else if (TIMEOUT_CYC != 0 && tmo_cnt_reg == TMO_LAST) begin
            mem_req_reg  <= 1'b0;
            tmo_cnt_reg  <= 32'h0;
            kill_reg     <= 1'b0;
            bus_err_reg  <= 1'b1;
            badvaddr_reg <= addr_reg;
            state_reg    <= ST_IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          if (accept && !flush) begin
            type_reg <= ld_type;
            addr_reg <= ld_addr;
            rd_reg   <= ld_rd;
            if (misaligned(ld_type, ld_addr[1:0])) begin
              state_reg    <= ST_ERR;
              adel_reg     <= 1'b1;
              badvaddr_reg <= ld_addr;
            end else begin
              state_reg    <= ST_REQ;
              mem_req_reg  <= 1'b1;
              mem_addr_reg <= {ld_addr[31:2], 2'b00};
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_load_unit.sv
// Randomized load traffic against a transaction-level model of the load unit.
module tb_dmem_load_unit;
  import cpu_pkg::*;

  localparam int          TMO   = 4;
  localparam logic [31:0] RBADV = 32'h0000_BAD0;

  logic        clk = 1'b0;
  logic        rst, ld_valid, flush;
  logic [2:0]  ld_type;
  logic [31:0] ld_addr;
  logic [4:0]  ld_rd;
  logic        stall, wb_valid, adel, bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, badvaddr;

  int          n_vec = 0;
  int          n_bad = 0;
  int          n_txn = 0;
  logic [31:0] exp_badv;

  dmem_load_unit_if bus ();

  dmem_load_unit #(.TIMEOUT_CYC(TMO), .RESET_BADV(RBADV)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_type  (ld_type),
    .ld_addr  (ld_addr),
    .ld_rd    (ld_rd),
    .flush    (flush),
    .stall    (stall),
    .mem      (bus),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .adel     (adel),
    .bus_err  (bus_err),
    .badvaddr (badvaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: pick the lane by byte offset, then extend by load kind.
  function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] d);
    int unsigned v;
    int unsigned off;
    off = a % 4;
    if (t == LD_LB || t == LD_LBU) begin
      v = (d >> (8 * off)) % 256;
      if (t == LD_LB && v >= 128) v = v - 256;
    end else if (t == LD_LH || t == LD_LHU) begin
      v = (d >> (16 * (off / 2))) % 65536;
      if (t == LD_LH && v >= 32768) v = v - 65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] t, input logic [31:0] a);
    int unsigned sz;
    if (t == LD_LB || t == LD_LBU) sz = 1;
    else if (t == LD_LH || t == LD_LHU) sz = 2;
    else sz = 4;
    return (a % sz) != 0;
  endfunction

  // flush_at: -1 none, -2 in the accept cycle, k>=0 in REQ cycle k.
  // ack_dly: REQ cycles without ack before the ack; >= TMO means never.
  task automatic run_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] d, input int ack_dly, input int flush_at);
    bit    killed = 0;
    bit    acked  = 0;
    string res;
    n_txn++;
    @(negedge clk);
    ld_valid = 1'b1; ld_type = t; ld_addr = a; ld_rd = rd;
    flush = (flush_at == -2); bus.mem_ack = 1'b0;
    #1 chk("stall_accept", stall, 1);
    @(negedge clk);
    ld_valid = 1'b0; flush = 1'b0;
    if (flush_at == -2) begin
      #1;
      chk("mreq_flush_acc", bus.mem_req, 0);
      chk("adel_flush_acc", adel, 0);
      chk("stall_flush_acc", stall, 0);
      res = "flushed at accept";
    end else if (ref_misaligned(t, a)) begin
      #1;
      exp_badv = a;
      chk("adel", adel, 1);
      chk("badv_adel", badvaddr, exp_badv);
      chk("mreq_adel", bus.mem_req, 0);
      chk("stall_err", stall, 0);
      res = "AdEL";
    end else begin
      for (int k = 0; k < TMO; k++) begin
        if (k > 0) @(negedge clk);
        bus.mem_ack   = (k == ack_dly);
        bus.mem_rdata = (k == ack_dly) ? d : $urandom;
        flush         = (k == flush_at);
        #1;
        chk("mreq_req", bus.mem_req, 1);
        chk("maddr", bus.mem_addr, a - (a % 4));
        chk("stall_req", stall, !(killed || flush));
        if (flush) killed = 1;
        if (k == ack_dly) begin
          acked = 1;
          break;
        end
      end
      @(negedge clk);
      bus.mem_ack = !acked;   // late ack after a timeout must be ignored
      flush = 1'b0;
      #1;
      chk("mreq_done", bus.mem_req, 0);
      chk("stall_done", stall, 0);
      if (!acked) begin
        exp_badv = a;
        chk("bus_err", bus_err, 1);
        chk("badv_tmo", badvaddr, exp_badv);
        chk("wbv_tmo", wb_valid, 0);
        res = "timeout";
      end else if (killed) begin
        chk("wbv_killed", wb_valid, 0);
        res = "killed";
      end else begin
        chk("wbv", wb_valid, 1);
        chk("wb_data", wb_data, ref_load(t, a, d));
        chk("wb_rd", wb_rd, rd);
        res = "written back";
      end
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("wbv_pulse", wb_valid, 0);
    chk("adel_pulse", adel, 0);
    chk("berr_pulse", bus_err, 0);
    chk("mreq_idle", bus.mem_req, 0);
    chk("badv_hold", badvaddr, exp_badv);
    $display("txn %0d type=%0d addr=%h rd=%0d ack_dly=%0d flush_at=%0d -> %s",
             n_txn, t, a, rd, ack_dly, flush_at, res);
  endtask

  initial begin
    logic [31:0] r1, r2;
    rst = 1'b1; ld_valid = 1'b0; flush = 1'b0; ld_type = 3'd0; ld_addr = 32'h0; ld_rd = 5'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
    exp_badv = RBADV;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_mreq", bus.mem_req, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_wbrd", wb_rd, 0);
    chk("rst_wbdata", wb_data, 0);
    chk("rst_adel", adel, 0);
    chk("rst_berr", bus_err, 0);
    chk("rst_badv", badvaddr, RBADV);
    @(negedge clk);
    rst = 1'b0;

    run_load(LD_LW,  32'h10, 5'd3, 32'hDEADBEEF, 0, -1);
    run_load(LD_LB,  32'h13, 5'd4, 32'h80FF7F01, 0, -1);
    run_load(LD_LBU, 32'h13, 5'd5, 32'h80FF7F01, 1, -1);
    run_load(LD_LH,  32'h12, 5'd6, 32'h80FF7F01, 2, -1);
    run_load(LD_LHU, 32'h12, 5'd7, 32'h80FF7F01, 0, -1);
    run_load(LD_LH,  32'h21, 5'd8, 32'h0, 0, -1);
    run_load(LD_LW,  32'h22, 5'd9, 32'h0, 0, -1);
    run_load(LD_LW,  32'h40, 5'd10, 32'h12345678, 3, 1);
    run_load(LD_LW,  32'h30, 5'd11, 32'h0, 99, -1);
    run_load(LD_LW,  32'h44, 5'd12, 32'h0, 0, -2);

    // Back-to-back: second load held on ld_valid and accepted in RESP.
    r1 = $urandom; r2 = $urandom;
    @(negedge clk);
    ld_valid = 1'b1; ld_type = LD_LW; ld_addr = 32'h0; ld_rd = 5'd1;
    #1 chk("b2b_stall0", stall, 1);
    @(negedge clk);
    ld_type = LD_LBU; ld_addr = 32'h5; ld_rd = 5'd2; bus.mem_ack = 1'b1; bus.mem_rdata = r1;
    #1 chk("b2b_maddr0", bus.mem_addr, 32'h0);
    chk("b2b_stall1", stall, 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1 chk("b2b_wbv0", wb_valid, 1);
    chk("b2b_data0", wb_data, r1);
    chk("b2b_rd0", wb_rd, 1);
    chk("b2b_stall2", stall, 1);
    @(negedge clk);
    ld_valid = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = r2;
    #1 chk("b2b_mreq1", bus.mem_req, 1);
    chk("b2b_maddr1", bus.mem_addr, 32'h4);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1 chk("b2b_wbv1", wb_valid, 1);
    chk("b2b_data1", wb_data, ref_load(LD_LBU, 32'h5, r2));
    chk("b2b_rd1", wb_rd, 2);
    @(negedge clk);
    #1 chk("b2b_wbv_end", wb_valid, 0);
    n_txn++;
    $display("txn %0d back-to-back LW 0x0 then LBU 0x5", n_txn);

    // Reset while a request is outstanding drops mem_req on the next edge.
    @(negedge clk);
    ld_valid = 1'b1; ld_type = LD_LW; ld_addr = 32'h80; ld_rd = 5'd13;
    @(negedge clk);
    ld_valid = 1'b0; rst = 1'b1;
    #1 chk("rstreq_mreq_pre", bus.mem_req, 1);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rstreq_mreq", bus.mem_req, 0);
    chk("rstreq_badv", badvaddr, RBADV);
    exp_badv = RBADV;
    n_txn++;
    $display("txn %0d reset during REQ", n_txn);

    for (int i = 0; i < 60; i++) begin
      logic [2:0]  t;
      logic [31:0] a;
      int          fa;
      int          dly;
      t   = 3'($urandom_range(0, 7));
      a   = $urandom;
      dly = $urandom_range(0, 5);
      fa  = -1;
      if (dly < TMO && $urandom_range(0, 4) == 0) fa = $urandom_range(0, 5) - 2;
      run_load(t, a, 5'($urandom), $urandom, dly, fa);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
